// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 16x32 register file, busy scoreboard, one-deep output register.
// Optional macro OF_WB_BYPASS_EN: forwards same-cycle writeback data to the read ports
// and evaluates busy after the same-cycle writeback clear.
module operand_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic        in_isImm,
  input  logic [31:0] in_imm,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [12:0] out_ctrl,
  output logic [3:0]  out_rd,
  output logic        err_illegal
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned CTRL_W = 13;

  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd12;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [NREG-1:0]   r_busy;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [3:0]        r_out_rd;
  logic              r_err;

  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_busy_eff;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_hazard;
  logic              w_legal;
  logic              w_accept;

  // Register reads, source usage and hazard detection
  always_comb begin
    w_clr_mask = wb_en ? (NREG'(1) << wb_rd) : '0;
`ifdef OF_WB_BYPASS_EN
    w_busy_eff = r_busy & ~w_clr_mask;
    w_rd_a     = (wb_en && (wb_rd == in_rs1)) ? wb_data : r_rf[in_rs1];
    w_rd_b     = (wb_en && (wb_rd == in_rs2)) ? wb_data : r_rf[in_rs2];
`else
    w_busy_eff = r_busy;
    w_rd_a     = r_rf[in_rs1];
    w_rd_b     = r_rf[in_rs2];
`endif
    w_use_rs1 = (in_op != OP_MOV);
    w_use_rs2 = !in_isImm && (in_op != OP_NOT);
    w_hazard  = (w_use_rs1 && w_busy_eff[in_rs1]) || (w_use_rs2 && w_busy_eff[in_rs2]);
    w_legal   = (in_op <= OP_ASR);
    in_ready  = !reset && !flush && (!r_out_valid || out_ready) && !w_hazard;
    w_accept  = in_valid && in_ready;
  end

  // Register file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // Busy scoreboard: flush clears all, issue set wins over writeback clear
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) |
                ((w_accept && w_legal && (in_op != OP_CMP)) ? (NREG'(1) << in_rd) : '0);
    end
  end

  // Output register: load on legal accept, hold while stalled, drop on consume or flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_ctrl  <= '0;
      r_out_rd    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_a     <= w_rd_a;
        r_out_b     <= in_isImm ? in_imm : w_rd_b;
        r_out_ctrl  <= CTRL_W'(1) << in_op;
        r_out_rd    <= in_rd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_A       = r_out_a;
  assign out_B       = r_out_b;
  assign out_ctrl    = r_out_ctrl;
  assign out_rd      = r_out_rd;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed scenarios then randomized traffic,
// all checked against a behavioural model of the stage.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_isImm, wb_en, flush, out_valid, out_ready, err_illegal;
  logic [3:0]  in_op, in_rd, in_rs1, in_rs2, wb_rd, out_rd;
  logic [31:0] in_imm, wb_data, out_A, out_B;
  logic [12:0] out_ctrl;

  int n_checks = 0;
  int n_errors = 0;

`ifdef OF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_isImm(in_isImm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_A(out_A), .out_B(out_B), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_rf [16];
  bit          m_busy [16];
  logic        m_valid = 0, m_err = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [12:0] m_ctrl = 0;
  logic [3:0]  m_rd = 0;

  initial for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (BYP && wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit m_is_busy(input logic [3:0] idx);
    if (BYP && wb_en && wb_rd == idx) return 0;
    return m_busy[idx];
  endfunction

  function automatic bit m_ready();
    bit need1, need2;
    if (reset || flush) return 0;
    if (m_valid && !out_ready) return 0;
    need1 = (in_op != 4'd9);
    need2 = !in_isImm && (in_op != 4'd8);
    if (need1 && m_is_busy(in_rs1)) return 0;
    if (need2 && m_is_busy(in_rs2)) return 0;
    return 1;
  endfunction

  // One clock: check in_ready, advance the model across the edge, check outputs
  task automatic cycle();
    bit acc, legal;
    logic [31:0] ra, rb;
    #1;
    chk("in_ready", in_ready, m_ready());
    acc   = in_valid && m_ready();
    legal = (in_op < 4'd13);
    ra    = m_read(in_rs1);
    rb    = in_isImm ? in_imm : m_read(in_rs2);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
      m_valid = 0; m_err = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0;
    end else begin
      if (wb_en) begin m_rf[wb_rd] = wb_data; m_busy[wb_rd] = 0; end
      if (acc && legal && in_op != 4'd5) m_busy[in_rd] = 1;
      if (flush) for (int i = 0; i < 16; i++) m_busy[i] = 0;
      m_err = acc && !legal;
      if (flush) m_valid = 0;
      else if (acc && legal) begin
        m_valid = 1; m_a = ra; m_b = rb; m_ctrl = 13'(1) << in_op; m_rd = in_rd;
      end else if (out_ready) m_valid = 0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("err_illegal", err_illegal, m_err);
    chk("out_A", out_A, m_a);
    chk("out_B", out_B, m_b);
    chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
    chk("out_rd", out_rd, m_rd);
  endtask

  task automatic quiet();
    reset = 0; in_valid = 0; wb_en = 0; flush = 0; out_ready = 1;
    in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_isImm = 0; in_imm = 0;
    wb_rd = 0; wb_data = 0;
  endtask

  task automatic offer(input logic [3:0] op, rd, rs1, rs2, input logic isimm, input logic [31:0] imm);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_isImm = isimm; in_imm = imm;
  endtask

  task automatic wb(input logic [3:0] rd, input logic [31:0] data);
    wb_en = 1; wb_rd = rd; wb_data = data;
  endtask

  initial begin
    quiet();
    reset = 1;
    @(negedge clk);
    cycle(); cycle();
    reset = 0;

    // Scenario 1: write r1/r2 then ADD
    wb(1, 5); cycle();
    wb(2, 7); cycle();
    wb_en = 0; offer(0, 3, 1, 2, 0, 0); cycle();
    in_valid = 0;
    chk("s1_valid", out_valid, 1); chk("s1_A", out_A, 5); chk("s1_B", out_B, 7);
    chk("s1_ctrl", 32'(out_ctrl), 32'h0001); chk("s1_rd", out_rd, 3);

    // Scenario 2: RAW hazard on r3 released by writeback
    offer(1, 5, 3, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin #1; chk("s2_stall", in_ready, 0); cycle(); end
    wb(3, 32'h33);
    #1; chk("s2_ready_wb", in_ready, 32'(BYP));
    cycle();
    wb_en = 0;
    if (BYP) in_valid = 0;
    chk("s2_valid_wb", out_valid, 32'(BYP));
    if (!BYP) begin
      #1; chk("s2_ready_after", in_ready, 1);
      cycle();
      in_valid = 0;
    end
    chk("s2_A", out_A, 32'h33); chk("s2_ctrl", 32'(out_ctrl), 32'h0002); chk("s2_B", out_B, 5);

    // Scenario 3: downstream stall then back-to-back load
    out_ready = 0; offer(6, 6, 1, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1; chk("s3_ready", in_ready, 0); cycle();
      chk("s3_hold_ctrl", 32'(out_ctrl), 32'h0002); chk("s3_hold_A", out_A, 32'h33);
    end
    out_ready = 1; cycle();
    in_valid = 0;
    chk("s3_ctrl", 32'(out_ctrl), 32'h0040); chk("s3_A", out_A, 5); chk("s3_B", out_B, 7);

    // Scenario 4: illegal opcode
    cycle();
    offer(14, 7, 1, 2, 0, 0); cycle();
    in_valid = 0;
    chk("s4_err", err_illegal, 1); chk("s4_valid", out_valid, 0);
    cycle();
    chk("s4_err_done", err_illegal, 0);

    // Scenario 5: MOV immediate into a busy destination
    offer(0, 4, 1, 2, 0, 0); cycle();
    offer(9, 4, 4, 4, 1, 32'hDEADBEEF);
    #1; chk("s5_ready", in_ready, 1);
    cycle();
    chk("s5_B", out_B, 32'hDEADBEEF); chk("s5_ctrl", 32'(out_ctrl), 32'h0200); chk("s5_rd", out_rd, 4);
    offer(0, 7, 4, 1, 0, 0);
    #1; chk("s5_busy4", in_ready, 0);
    cycle();
    in_valid = 0;

    // Scenario 6: flush with busy = 0x000A, then reset during a stall
    flush = 1; cycle(); flush = 0;
    offer(0, 1, 2, 2, 0, 0); cycle();
    offer(0, 3, 2, 2, 0, 0); cycle();
    in_valid = 0; out_ready = 0; flush = 1; wb(9, 32'h99); cycle();
    flush = 0; wb_en = 0;
    chk("s6_valid", out_valid, 0);
    offer(0, 8, 1, 3, 0, 0);
    #1; chk("s6_busy_clear", in_ready, 1);
    cycle();
    offer(7, 10, 9, 2, 0, 0); cycle();
    chk("s6_stall_valid", out_valid, 1);
    reset = 1;
    #1; chk("s6_rst_ready", in_ready, 0);
    cycle();
    reset = 0; in_valid = 0; out_ready = 1;
    chk("s6_rst_valid", out_valid, 0); chk("s6_rst_A", out_A, 0); chk("s6_rst_B", out_B, 0);
    chk("s6_rst_ctrl", 32'(out_ctrl), 0); chk("s6_rst_rd", out_rd, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 4'($urandom_range(0, 15));
      wb_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 4'($urandom_range(0, 15));
      in_rd     = 4'($urandom_range(0, 15));
      in_rs1    = 4'($urandom_range(0, 15));
      in_rs2    = 4'($urandom_range(0, 15));
      in_isImm  = ($urandom_range(0, 9) < 3);
      in_imm    = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 The input port group SHALL be: in_valid input 1 (instruction offered); in_ready output 1 (instruction accepted this cycle); in_op input 4 (opcode); in_rd input 4 (destination register); in_rs1 input 4 (source 1); in_rs2 input 4 (source 2); in_isImm input 1 (B from immediate); in_imm input 32 (immediate).
REQ-003 The writeback port group SHALL be: wb_en input 1 (register write); wb_rd input 4 (write index); wb_data input 32 (write data).
REQ-004 The control port group SHALL be: flush input 1 (kill held instruction).
REQ-005 The output port group SHALL be: out_valid output 1 (operands valid); out_ready input 1 (ALU consumes); out_A output 32; out_B output 32; out_ctrl output 13 (one-hot ALU select); out_rd output 4; err_illegal output 1 (one-cycle illegal-opcode pulse).

Function
REQ-006 The block SHALL hold a 16x32 register file, all entries writable, with one write port (wb) and two combinational read ports (rs1, rs2).
REQ-007 Opcode SHALL map to out_ctrl bit: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 CMP, 6 OR, 7 AND, 8 NOT, 9 MOV, 10 LSL, 11 LSR, 12 ASR; exactly one bit is set whenever out_valid=1.
REQ-008 Source use: rs1 is used unless op=MOV; rs2 is used unless in_isImm=1 or op=NOT.
REQ-009 Operand selection: out_A = regfile[rs1]; out_B = in_imm if in_isImm, else regfile[rs2].
REQ-010 The block SHALL keep a 16-bit busy scoreboard; accepting any non-CMP legal op sets busy[in_rd]; wb_en clears busy[wb_rd]; when set and clear hit the same index in one cycle, set SHALL win.
REQ-011 in_ready SHALL be 1 iff flush=0, (out_valid=0 or out_ready=1), and no used source is busy after the same-cycle clear (REQ-019).
REQ-012 Accept = in_valid and in_ready; on accept with a legal op, the output register SHALL load next edge and out_valid SHALL be 1 (latency 1 cycle).
REQ-013 Opcodes 13-15 SHALL be accepted and dropped: no output load, no busy change, err_illegal=1 for the following cycle only.
REQ-014 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-015 out_ready=1 with no new accept SHALL clear out_valid next edge; a consume and a new accept in the same cycle SHALL give back-to-back issue.
REQ-016 flush=1 SHALL clear out_valid and the entire busy vector next edge; a same-cycle wb write SHALL still update the register file.
REQ-017 A wb write to the register being read in the same cycle SHALL be governed by REQ-019.
REQ-018 out_* data fields SHALL retain their last values when out_valid=0.

Configuration
REQ-019 With macro OF_WB_BYPASS_EN defined, a read of wb_rd with wb_en=1 SHALL return wb_data, and busy is evaluated after the same-cycle clear. Without the macro, such a read SHALL return the old value, and in_ready SHALL stay low until the cycle after the clear.

Reset
REQ-020 When reset=1 at a rising edge, the following SHALL be zero next cycle: out_valid, out_A, out_B, out_ctrl, out_rd, err_illegal, busy, and every register file entry.
REQ-021 Reset SHALL override accept, wb and flush in the same cycle; in_ready SHALL be 0 during reset.

Verification
REQ-022 Scenario 1: wb r1=5, r2=7; then ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, A=5, B=7, out_ctrl=0x0001, out_rd=3.
REQ-023 Scenario 2: issue ADD rd=3, then SUB rs1=3 -> in_ready=0 until wb_rd=3. With the macro, accept occurs in the wb cycle and A=wb_data; without it, accept occurs one cycle later.
REQ-024 Scenario 3: out_ready=0 for 3 cycles with out_valid=1 -> outputs constant and in_ready=0; out_ready=1 with in_valid=1 -> new instruction loads next edge.
REQ-025 Scenario 4: in_op=14 -> err_illegal pulses 1 cycle, out_valid unchanged, busy unchanged.
REQ-026 Scenario 5: MOV rd=4 with in_isImm=1, imm=0xDEADBEEF, while r4 is busy -> accepted (no sources used), B=0xDEADBEEF; busy[4] remains set.
REQ-027 Scenario 6: flush with out_valid=1 and busy=0x000A -> next cycle out_valid=0 and busy=0; reset mid-stall -> all outputs 0.
